// File: rtl/placement_pkg.sv
// Shared definitions for the placement checker: FSM encoding, error codes
// and sentinel values used by the memories.
package placement_pkg;

  typedef enum logic [3:0] {
    IDLE,
    EDGE,
    POSA,
    POSB,
    GRIDA,
    GRIDB,
    ACCUM,
    FIN,
    WAIT
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_UNPLACED = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_GRID     = 2'd3;

  localparam int EMPTY_CELL  = -1;
  localparam int UNPLACED_X  = -1;

  function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/placement_dist.sv
// Combinational Manhattan distance terms for one edge: the plain wirelength
// term and the term for a fabric whose links span two PEs per hop.
module placement_dist
  import placement_pkg::*;
#(
  parameter int coord_width = 5
) (
  input  logic signed [coord_width-1:0] ax_i,
  input  logic signed [coord_width-1:0] ay_i,
  input  logic signed [coord_width-1:0] bx_i,
  input  logic signed [coord_width-1:0] by_i,
  output logic signed [31:0]            cost_term_o,
  output logic signed [31:0]            hop_term_o
);

  logic signed [31:0] axExt, ayExt, bxExt, byExt;
  logic signed [31:0] absDx, absDy;

  assign axExt = {{(32-coord_width){ax_i[coord_width-1]}}, ax_i};
  assign ayExt = {{(32-coord_width){ay_i[coord_width-1]}}, ay_i};
  assign bxExt = {{(32-coord_width){bx_i[coord_width-1]}}, bx_i};
  assign byExt = {{(32-coord_width){by_i[coord_width-1]}}, by_i};

  assign absDx = abs32(axExt - bxExt);
  assign absDy = abs32(ayExt - byExt);

  // Both distances are non-negative, so (d+1)>>>1 is ceil(d/2).
  assign cost_term_o = absDx + absDy - 32'sd1;
  assign hop_term_o  = ((absDx + 32'sd1) >>> 1) + ((absDy + 32'sd1) >>> 1) - 32'sd1;

endmodule

// File: rtl/placement_checker.sv
// Walks an edge list, validates each endpoint's placement against the
// position and grid memories, and accumulates the total wirelength.
module placement_checker #(
  parameter int grid_size          = 4,
  parameter int max_edges_width    = 8,
  parameter int mem_edges_depth    = 8,
  parameter int mem_edges_width    = 8,
  parameter int mem_position_depth = 7,
  parameter int mem_position_width = 5,
  parameter int mem_grid_depth     = 7,
  parameter int mem_grid_width     = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [max_edges_width-1:0]             n_edge,
  output logic                                   rd_en_edges,
  output logic [mem_edges_depth-1:0]             addr_edges,
  input  logic signed [2*mem_edges_width-1:0]    rd_edges_data,
  output logic                                   rd_en_mem_position,
  output logic [mem_position_depth-1:0]          addr_mem_position,
  input  logic signed [2*mem_position_width-1:0] rd_mem_position_data,
  output logic                                   rd_en_mem_grid,
  output logic [mem_grid_depth-1:0]              addr_mem_grid,
  input  logic signed [mem_grid_width-1:0]       rd_mem_grid_data,
  output logic                                   busy,
  output logic                                   done,
  output logic [1:0]                             err_code,
  output logic [max_edges_width-1:0]             err_edge,
  output logic signed [31:0]                     cost,
  output logic signed [31:0]                     cost_1hop
);
  import placement_pkg::*;

  localparam int EW = mem_edges_width;
  localparam int PW = mem_position_width;

  state_e state_q, state_d, nextState_q, nextState_d;
  logic   sample_q, sample_d;
  logic   busy_q, busy_d, done_q, done_d;
  logic [1:0] errCode_q, errCode_d;
  logic [max_edges_width-1:0] idx_q, idx_d, errEdge_q, errEdge_d;
  logic signed [EW-1:0] aNode_q, aNode_d, bNode_q, bNode_d;
  logic signed [PW-1:0] ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
  logic signed [31:0] cost_q, cost_d, costHop_q, costHop_d;

  logic signed [EW-1:0] rdA, rdB;
  logic signed [PW-1:0] rdX, rdY, gridX, gridY;
  logic [1:0] posErr;
  logic [mem_grid_depth-1:0] gridAddr;
  logic cellMatchA, cellMatchB;
  logic signed [31:0] costTerm, hopTerm;

  function automatic logic [1:0] posCheck(input logic signed [PW-1:0] x,
                                          input logic signed [PW-1:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (xi == UNPLACED_X) return ERR_UNPLACED;
    if (xi < 0 || xi >= grid_size || yi < 0 || yi >= grid_size) return ERR_RANGE;
    return ERR_OK;
  endfunction

  assign rdA = rd_edges_data[EW-1:0];
  assign rdB = rd_edges_data[2*EW-1:EW];
  assign rdX = rd_mem_position_data[PW-1:0];
  assign rdY = rd_mem_position_data[2*PW-1:PW];
  assign posErr = posCheck(rdX, rdY);

  // The grid address only matters once the range check has passed, so any
  // wrap into mem_grid_depth bits is harmless.
  assign gridX    = (state_q == GRIDB) ? bx_q : ax_q;
  assign gridY    = (state_q == GRIDB) ? by_q : ay_q;
  assign gridAddr = mem_grid_depth'(int'(gridX) * grid_size + int'(gridY));

  assign cellMatchA = (int'(rd_mem_grid_data) == int'(aNode_q));
  assign cellMatchB = (int'(rd_mem_grid_data) == int'(bNode_q));

  placement_dist #(.coord_width(PW)) u_dist (
    .ax_i        (ax_q),
    .ay_i        (ay_q),
    .bx_i        (bx_q),
    .by_i        (by_q),
    .cost_term_o (costTerm),
    .hop_term_o  (hopTerm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      nextState_q <= IDLE;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      errCode_q   <= ERR_OK;
      errEdge_q   <= '0;
      idx_q       <= '0;
      aNode_q     <= '0;
      bNode_q     <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      cost_q      <= '0;
      costHop_q   <= '0;
    end else begin
      state_q     <= state_d;
      nextState_q <= nextState_d;
      sample_q    <= sample_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      errCode_q   <= errCode_d;
      errEdge_q   <= errEdge_d;
      idx_q       <= idx_d;
      aNode_q     <= aNode_d;
      bNode_q     <= bNode_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      cost_q      <= cost_d;
      costHop_q   <= costHop_d;
    end
  end

  // Each read state runs twice: first pass issues the read and parks in WAIT,
  // second pass (sample_q=1) consumes the data that is valid two cycles later.
  always_comb begin
    state_d     = state_q;
    nextState_d = nextState_q;
    sample_d    = sample_q;
    busy_d      = busy_q;
    done_d      = done_q;
    errCode_d   = errCode_q;
    errEdge_d   = errEdge_q;
    idx_d       = idx_q;
    aNode_d     = aNode_q;
    bNode_d     = bNode_q;
    ax_d        = ax_q;
    ay_d        = ay_q;
    bx_d        = bx_q;
    by_d        = by_q;
    cost_d      = cost_q;
    costHop_d   = costHop_q;
    rd_en_edges        = 1'b0;
    addr_edges         = '0;
    rd_en_mem_position = 1'b0;
    addr_mem_position  = '0;
    rd_en_mem_grid     = 1'b0;
    addr_mem_grid      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cost_d    = '0;
          costHop_d = '0;
          errCode_d = ERR_OK;
          errEdge_d = '0;
          done_d    = 1'b0;
          idx_d     = '0;
          busy_d    = 1'b1;
          sample_d  = 1'b0;
          state_d   = EDGE;
        end
      end
      EDGE: begin
        if (!sample_q) begin
          if (idx_q == n_edge) begin
            state_d = FIN;
          end else begin
            rd_en_edges = 1'b1;
            addr_edges  = mem_edges_depth'(idx_q);
            nextState_d = EDGE;
            sample_d    = 1'b1;
            state_d     = WAIT;
          end
        end else begin
          aNode_d  = rdA;
          bNode_d  = rdB;
          sample_d = 1'b0;
          state_d  = POSA;
        end
      end
      POSA, POSB: begin
        if (!sample_q) begin
          rd_en_mem_position = 1'b1;
          addr_mem_position  = (state_q == POSA) ? mem_position_depth'(aNode_q)
                                                 : mem_position_depth'(bNode_q);
          nextState_d = state_q;
          sample_d    = 1'b1;
          state_d     = WAIT;
        end else begin
          sample_d = 1'b0;
          if (state_q == POSA) begin
            ax_d = rdX;
            ay_d = rdY;
          end else begin
            bx_d = rdX;
            by_d = rdY;
          end
          if (posErr != ERR_OK) begin
            errCode_d = posErr;
            errEdge_d = idx_q;
            state_d   = FIN;
          end else begin
            state_d = (state_q == POSA) ? POSB : GRIDA;
          end
        end
      end
      GRIDA, GRIDB: begin
        if (!sample_q) begin
          rd_en_mem_grid = 1'b1;
          addr_mem_grid  = gridAddr;
          nextState_d    = state_q;
          sample_d       = 1'b1;
          state_d        = WAIT;
        end else begin
          sample_d = 1'b0;
          if ((state_q == GRIDA) ? !cellMatchA : !cellMatchB) begin
            errCode_d = ERR_GRID;
            errEdge_d = idx_q;
            state_d   = FIN;
          end else begin
            state_d = (state_q == GRIDA) ? GRIDB : ACCUM;
          end
        end
      end
      ACCUM: begin
        cost_d    = cost_q + costTerm;
        costHop_d = costHop_q + hopTerm;
        idx_d     = idx_q + 1'b1;
        state_d   = EDGE;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      WAIT: begin
        state_d = nextState_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_code  = errCode_q;
  assign err_edge  = errEdge_q;
  assign cost      = cost_q;
  assign cost_1hop = costHop_q;

endmodule

// File: tb/tb_placement_checker.sv
// Self-checking bench: memories with two-cycle read latency plus a
// behavioural model of the whole check, compared whenever done rises.
module tb_placement_checker;

  logic               clk;
  logic               reset;
  logic               start;
  logic [7:0]         n_edge;
  logic               rd_en_edges;
  logic [7:0]         addr_edges;
  logic signed [15:0] rd_edges_data;
  logic               rd_en_mem_position;
  logic [6:0]         addr_mem_position;
  logic signed [9:0]  rd_mem_position_data;
  logic               rd_en_mem_grid;
  logic [6:0]         addr_mem_grid;
  logic signed [7:0]  rd_mem_grid_data;
  logic               busy;
  logic               done;
  logic [1:0]         err_code;
  logic [7:0]         err_edge;
  logic signed [31:0] cost;
  logic signed [31:0] cost_1hop;

  logic [15:0] edgeMem [256];
  logic [9:0]  posMem  [128];
  logic [7:0]  gridMem [128];
  logic [15:0] edgePipe;
  logic [9:0]  posPipe;
  logic [7:0]  gridPipe;

  int assertCount = 0;
  int failCount   = 0;
  int edgeReads, posReads, gridReads;
  int expErr, expEdge, expCost, expHop, expGridReads;
  logic doneSeen = 1'b0;

  placement_checker dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .n_edge               (n_edge),
    .rd_en_edges          (rd_en_edges),
    .addr_edges           (addr_edges),
    .rd_edges_data        (rd_edges_data),
    .rd_en_mem_position   (rd_en_mem_position),
    .addr_mem_position    (addr_mem_position),
    .rd_mem_position_data (rd_mem_position_data),
    .rd_en_mem_grid       (rd_en_mem_grid),
    .addr_mem_grid        (addr_mem_grid),
    .rd_mem_grid_data     (rd_mem_grid_data),
    .busy                 (busy),
    .done                 (done),
    .err_code             (err_code),
    .err_edge             (err_edge),
    .cost                 (cost),
    .cost_1hop            (cost_1hop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle read latency: address registered, then output registered.
  always @(posedge clk) begin
    if (rd_en_edges)        edgePipe <= edgeMem[addr_edges];
    if (rd_en_mem_position) posPipe  <= posMem[addr_mem_position];
    if (rd_en_mem_grid)     gridPipe <= gridMem[addr_mem_grid];
    rd_edges_data        <= edgePipe;
    rd_mem_position_data <= posPipe;
    rd_mem_grid_data     <= gridPipe;
  end

  always @(negedge clk) begin
    if (rd_en_edges)        edgeReads++;
    if (rd_en_mem_position) posReads++;
    if (rd_en_mem_grid)     gridReads++;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Model and DUT agree every time a check completes.
  always @(negedge clk) begin
    if (done && !doneSeen) begin
      checkOutput("model_err_code", err_code, expErr);
      checkOutput("model_err_edge", err_edge, expEdge);
      checkOutput("model_cost", cost, expCost);
      checkOutput("model_cost_1hop", cost_1hop, expHop);
      checkOutput("model_grid_reads", gridReads, expGridReads);
      checkOutput("busy_at_done", busy, 0);
    end
    doneSeen = done;
  end

  function automatic int posCode(input int x, input int y);
    if (x == -1) return 1;
    if (x < 0 || x >= 4 || y < 0 || y >= 4) return 2;
    return 0;
  endfunction

  function automatic int absI(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void modelRun(input int n, output int eCode, output int eEdge,
                                   output int c, output int h, output int gReads);
    c = 0; h = 0; eCode = 0; eEdge = 0; gReads = 0;
    for (int k = 0; k < n; k++) begin
      logic [15:0] ew;
      logic [9:0]  pa, pb;
      int a, b, ax, ay, bx, by, code, dx, dy;
      ew = edgeMem[k];
      a  = int'($signed(ew[7:0]));
      b  = int'($signed(ew[15:8]));
      pa = posMem[a & 127];
      pb = posMem[b & 127];
      ax = int'($signed(pa[4:0])); ay = int'($signed(pa[9:5]));
      bx = int'($signed(pb[4:0])); by = int'($signed(pb[9:5]));
      code = posCode(ax, ay);
      if (code == 0) code = posCode(bx, by);
      if (code != 0) begin eCode = code; eEdge = k; return; end
      gReads++;
      if (int'($signed(gridMem[(ax * 4 + ay) & 127])) != a) begin eCode = 3; eEdge = k; return; end
      gReads++;
      if (int'($signed(gridMem[(bx * 4 + by) & 127])) != b) begin eCode = 3; eEdge = k; return; end
      dx = ax - bx;
      dy = ay - by;
      c += absI(dx) + absI(dy) - 1;
      h += (absI(dx) + 1) / 2 + (absI(dy) + 1) / 2 - 1;
    end
  endfunction

  task automatic clearMem();
    for (int k = 0; k < 256; k++) edgeMem[k] = '0;
    for (int k = 0; k < 128; k++) begin
      posMem[k]  = 10'h3FF;
      gridMem[k] = 8'hFF;
    end
  endtask

  task automatic setEdge(input int k, input int a, input int b);
    edgeMem[k] = {8'(b), 8'(a)};
  endtask

  task automatic setPos(input int node, input int x, input int y);
    posMem[node] = {5'(y), 5'(x)};
  endtask

  task automatic setupSingle();
    clearMem();
    setEdge(0, 0, 1);
    setPos(0, 0, 0);
    setPos(1, 2, 3);
    gridMem[0]  = 8'd0;
    gridMem[11] = 8'd1;
  endtask

  task automatic startRun(input int n);
    modelRun(n, expErr, expEdge, expCost, expHop, expGridReads);
    @(negedge clk);
    edgeReads = 0; posReads = 0; gridReads = 0;
    n_edge = 8'(n);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_seen", done, 1);
  endtask

  task automatic applyStimulus(input int n, output int cyc);
    startRun(n);
    waitDone(cyc);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; n_edge = '0;
    clearMem();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_err_edge", err_edge, 0);
    checkOutput("rst_cost", cost, 0);
    checkOutput("rst_cost_1hop", cost_1hop, 0);
    checkOutput("rst_rd_en", {rd_en_edges, rd_en_mem_position, rd_en_mem_grid}, 0);
    checkOutput("rst_addrs", {addr_edges, addr_mem_position, addr_mem_grid}, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single edge");
    setupSingle();
    applyStimulus(1, cyc);
    checkOutput("single_err", err_code, 0);
    checkOutput("single_cost", cost, 4);
    checkOutput("single_hop", cost_1hop, 2);
    repeat (3) @(negedge clk);
    checkOutput("done_held", done, 1);

    $display("[TB] empty check");
    applyStimulus(0, cyc);
    checkOutput("empty_within_3", (cyc <= 3) ? 1 : 0, 1);
    checkOutput("empty_cost", cost, 0);
    checkOutput("empty_err", err_code, 0);
    checkOutput("empty_reads", edgeReads + posReads + gridReads, 0);

    $display("[TB] unplaced endpoint");
    setupSingle();
    setPos(1, -1, 3);
    applyStimulus(1, cyc);
    checkOutput("unplaced_err", err_code, 1);
    checkOutput("unplaced_edge", err_edge, 0);
    checkOutput("unplaced_grid_reads", gridReads, 0);

    $display("[TB] out of range");
    setupSingle();
    setPos(1, 4, 0);
    applyStimulus(1, cyc);
    checkOutput("range_err", err_code, 2);

    $display("[TB] grid mismatch on second edge");
    clearMem();
    setEdge(0, 0, 3);
    setEdge(1, 0, 2);
    setPos(0, 0, 0); gridMem[0]  = 8'd0;
    setPos(3, 1, 1); gridMem[5]  = 8'd3;
    setPos(2, 2, 3); gridMem[11] = 8'd7;
    applyStimulus(2, cyc);
    checkOutput("grid_err", err_code, 3);
    checkOutput("grid_edge", err_edge, 1);
    checkOutput("grid_cost", cost, 1);
    checkOutput("grid_hop", cost_1hop, 1);

    $display("[TB] three edges, coincident endpoints, start while busy");
    setupSingle();
    setEdge(1, 0, 0);
    setEdge(2, 1, 3);
    setPos(3, 1, 1); gridMem[5] = 8'd3;
    startRun(3);
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc);
    @(negedge clk);
    checkOutput("multi_err", err_code, 0);
    checkOutput("multi_cost", cost, 5);
    checkOutput("multi_hop", cost_1hop, 2);

    $display("[TB] reset during grid read");
    setupSingle();
    startRun(1);
    cyc = 0;
    while (!rd_en_mem_grid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reached_grida", rd_en_mem_grid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_rd_en", {rd_en_edges, rd_en_mem_position, rd_en_mem_grid}, 0);
    checkOutput("midrst_cost", cost, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, cyc);
    checkOutput("after_rst_err", err_code, 0);
    checkOutput("after_rst_cost", cost, 4);
    checkOutput("after_rst_hop", cost_1hop, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/placement_checker.md
PLACEMENT_CHECKER -- requirements
Module: placement_checker

Interface
REQ-001 The block SHALL have parameter grid_size, default 4, meaning grid edge length in PEs.
REQ-002 The block SHALL have parameter max_edges_width, default 8, meaning n_edge width.
REQ-003 The block SHALL have parameters mem_edges_depth=8 and mem_edges_width=8, meaning the edge memory address width and the node-id width.
REQ-004 The block SHALL have parameters mem_position_depth=7 and mem_position_width=5, meaning the position memory address width and the signed width of each X/Y coordinate.
REQ-005 The block SHALL have parameters mem_grid_depth=7 and mem_grid_width=8, meaning the grid memory address width and the signed width of a cell.
REQ-006 clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle request to begin a check.
REQ-009 n_edge  in  max_edges_width  number of edges to check.
REQ-010 rd_en_edges / addr_edges  out  1 / mem_edges_depth  edge memory read port.
REQ-011 rd_edges_data  in  2*mem_edges_width  signed; [low]=a, [high]=b.
REQ-012 rd_en_mem_position / addr_mem_position  out  1 / mem_position_depth  position memory read port.
REQ-013 rd_mem_position_data  in  2*mem_position_width  signed; [low]=X, [high]=Y.
REQ-014 rd_en_mem_grid / addr_mem_grid  out  1 / mem_grid_depth  grid memory read port.
REQ-015 rd_mem_grid_data  in  mem_grid_width  signed; -1 = empty cell.
REQ-016 busy  out  1  check in progress.
REQ-017 done  out  1  check complete; held until the next accepted start.
REQ-018 err_code  out  2  0=ok, 1=unplaced, 2=out of range, 3=grid mismatch.
REQ-019 err_edge  out  max_edges_width  index of the failing edge.
REQ-020 cost / cost_1hop  out  32 each  signed wirelength totals.

Function
REQ-021 Read protocol: rd_en_* high for exactly 1 cycle N with its address; data sampled in cycle N+2 after one wait state; all rd_en_* are 0 in every other cycle.
REQ-022 The FSM SHALL have states IDLE, EDGE, POSA, POSB, GRIDA, GRIDB, ACCUM, FIN and WAIT; WAIT returns to a registered next_state.
REQ-023 IDLE: start=1 clears cost, cost_1hop, err_code, err_edge, done and index i, sets busy=1, and goes to EDGE; start while busy=1 is ignored.
REQ-024 EDGE: if i==n_edge go to FIN; otherwise issue an edge read at addr i and latch a, b.
REQ-025 POSA / POSB: issue a position read at addr a / b and latch (ax,ay) / (bx,by).
REQ-026 Unplaced check: X == -1 on either endpoint gives err_code=1.
REQ-027 Range check: otherwise, a coordinate <0 or >=grid_size gives err_code=2.
REQ-028 GRIDA / GRIDB: issue a grid read at ax*grid_size+ay / bx*grid_size+by; a cell value not equal to a / b gives err_code=3.
REQ-029 Check priority: per edge, check order is POSA, POSB, GRIDA, GRIDB; the first error sets err_edge=i and goes to FIN, with no further reads issued.
REQ-030 ACCUM: cost += |dx|+|dy|-1; cost_1hop += ceil(|dx|/2)+ceil(|dy|/2)-1, with dx=ax-bx and dy=ay-by sign-extended to 32 bits.
REQ-031 ACCUM exit: i increments and the FSM returns to EDGE.
REQ-032 FIN: done=1, busy=0, go to IDLE; cost values stay frozen at their partial totals when an error occurs.
REQ-033 n_edge=0: done is asserted within 3 cycles of start, with cost=0 and err_code=0.
REQ-034 Coincident endpoints (a==b): cost decreases by 1 for that edge; this is not an error.
REQ-035 Grid address: computed in mem_grid_depth bits, with wrap permitted only after the range check has passed.

Reset
REQ-036 On reset: state=IDLE; all rd_en_* and addresses=0; busy=0, done=0, err_code=0, err_edge=0, cost=0, cost_1hop=0.
REQ-037 Reset mid-check: abandons the check at the same edge; no read enable is asserted in the following cycle.

Structure
REQ-038 The shared package placement_pkg SHALL hold the FSM state encoding, the err_code constants, and EMPTY_CELL=-1.
REQ-039 Sub-module placement_dist (combinational): takes ax, ay, bx, by and returns the per-edge cost and 1-hop cost terms; it is instantiated once.

Verification
REQ-040 Single edge: n_edge=1, edge0=(0,1), pos0=(0,0), pos1=(2,3), grid[0]=0, grid[11]=1 -> done=1, err_code=0, cost=4, cost_1hop=2.
REQ-041 Empty check: n_edge=0 -> done within 3 cycles, cost=0, and no rd_en_* is ever asserted.
REQ-042 Unplaced endpoint: as REQ-040 but pos1 X = -1 -> err_code=1, err_edge=0, and no grid read occurs.
REQ-043 Out of range: as REQ-040 but pos1=(4,0) -> err_code=2.
REQ-044 Grid mismatch: two edges, where edge1 has grid[11]=7 -> err_code=3, err_edge=1, and cost equals the edge0 cost only.
REQ-045 Reset mid-check: reset asserted while in GRIDA -> next cycle all outputs are at reset values; a following start reproduces the REQ-040 result exactly.
